// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned WIDTH x WIDTH shift-and-add multiplier that borrows the shared ALU adder.
// One ADD/SHIFT pair per multiplier bit; product is loaded on entry to DONE so it is valid with done.
module alu_mul_seq #(
    parameter int          WIDTH   = 4,
    parameter logic [2:0]  ALU_ADD = 3'b010
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           alu_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_r,
    input  logic                 alu_cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d, acc_q, acc_d, q_q, q_d;
    logic                 c_q, c_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 last;

    assign last = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d = a;
                q_d     = b;
                acc_d   = '0;
                c_d     = 1'b0;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                {c_d, acc_d} = q_q[0] ? {alu_cout, alu_r} : {1'b0, acc_q};
                state_d      = SHIFT;
            end
            SHIFT: begin
                {acc_d, q_d} = {c_q, acc_q, q_q[WIDTH-1:1]};
                c_d          = 1'b0;
                cnt_d        = last ? cnt_q : cnt_q + CW'(1);
                state_d      = last ? DONE : ADD;
                // Loading here makes product change exactly as done rises.
                if (last) product_d = {c_q, acc_q, q_q[WIDTH-1:1]};
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign product = product_q;
    assign alu_op  = ALU_ADD;
    assign alu_a   = acc_q;
    assign alu_b   = mcand_q;
endmodule
